// File: rtl/lc_noc_injector_pkg.sv
// Shared packet layout and helpers for the local-controller NoC injector.
package lc_noc_injector_pkg;

    localparam int DATAWIDTH  = 16;
    localparam int ADDR_VEC_W = 8;

    // Payload is two samples wide; the destination vector sits on top.
    function automatic int calc_packet_width(input int dw, input int avw);
        return 2 * dw + avw;
    endfunction

    localparam int PACKET_W = calc_packet_width(DATAWIDTH, ADDR_VEC_W);
    localparam int DEST_MSB = PACKET_W - 1;
    localparam int DEST_LSB = PACKET_W - ADDR_VEC_W;
    localparam int DATA_MSB = 2 * DATAWIDTH - 1;
    localparam int DATA_LSB = 0;

    // Destination fields are zero-extended to this width before testing.
    localparam int DEST_MAX_W = 64;

    // A slot carries no packet when its destination is zero or undriven.
    function automatic logic dest_is_empty(input logic [DEST_MAX_W-1:0] dest);
        return (dest == '0) || (^dest === 1'bx);
    endfunction

endpackage

// File: rtl/lc_pkt_fifo.sv
// Small synchronous FIFO; a push into a full FIFO is taken only if it is popped the same cycle.
module lc_pkt_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally since DEPTH is a power of two; flush wins over push/pop.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge CLK) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lc_noc_injector.sv
// Buffers the live and prefetch streams of one local controller and arbitrates them onto a router port.
module lc_noc_injector
    import lc_noc_injector_pkg::*;
#(
    parameter int  datawidth            = 16,
    parameter int  address_vector_width = 8,
    parameter int  fifo_depth           = 4,
    parameter int  starve_limit         = 8,
    localparam int packet_width         = calc_packet_width(datawidth, address_vector_width)
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic [packet_width-1:0] packet_in,
    input  logic [packet_width-1:0] prefetch_packet_in,
    input  logic                    scenario_update,
    output logic [packet_width-1:0] out_packet,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_is_prefetch,
    output logic                    live_full,
    output logic                    prefetch_full,
    output logic                    overflow,
    output logic [7:0]              drop_count
);

    localparam int SCW = $clog2(starve_limit + 1);

    logic [address_vector_width-1:0] live_dest;
    logic [address_vector_width-1:0] pf_dest;
    logic                    live_req, pf_req;
    logic                    live_empty, pf_empty;
    logic                    live_drop, pf_drop;
    logic                    live_pop, pf_pop;
    logic                    load, pf_avail, pick_pf;
    logic [packet_width-1:0] live_dout, pf_dout;
    logic [SCW-1:0]          starve_cnt;
    logic [8:0]              drop_sum;

    assign live_dest = packet_in[packet_width-1 -: address_vector_width];
    assign pf_dest   = prefetch_packet_in[packet_width-1 -: address_vector_width];

    // Prefetch pushes coinciding with a scenario change are stale and silently discarded.
    assign live_req = !dest_is_empty(DEST_MAX_W'(live_dest));
    assign pf_req   = !dest_is_empty(DEST_MAX_W'(pf_dest)) && !scenario_update;

    // The prefetch FIFO is flushed at a scenario edge, so it must not feed the output then.
    assign load     = !out_valid || out_ready;
    assign pf_avail = !pf_empty && !scenario_update;
    assign pick_pf  = pf_avail && (live_empty || starve_cnt == SCW'(starve_limit));
    assign pf_pop   = load && pick_pf;
    assign live_pop = load && !live_empty && !pick_pf;

    assign live_drop = live_req && live_full && !live_pop;
    assign pf_drop   = pf_req && prefetch_full && !pf_pop;
    assign drop_sum  = {1'b0, drop_count} + 9'(live_drop) + 9'(pf_drop);

    lc_pkt_fifo #(.WIDTH(packet_width), .DEPTH(fifo_depth)) u_live_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (live_req),
        .pop   (live_pop),
        .flush (1'b0),
        .din   (packet_in),
        .full  (live_full),
        .empty (live_empty),
        .dout  (live_dout)
    );

    lc_pkt_fifo #(.WIDTH(packet_width), .DEPTH(fifo_depth)) u_pf_fifo (
        .CLK   (CLK),
        .reset (reset),
        .push  (pf_req),
        .pop   (pf_pop),
        .flush (scenario_update),
        .din   (prefetch_packet_in),
        .full  (prefetch_full),
        .empty (pf_empty),
        .dout  (pf_dout)
    );

    // One-entry output register: holds steady under backpressure, refills on transfer.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            out_valid       <= 1'b0;
            out_packet      <= '0;
            out_is_prefetch <= 1'b0;
        end else if (load) begin
            out_valid <= live_pop || pf_pop;
            if (pf_pop) begin
                out_packet      <= pf_dout;
                out_is_prefetch <= 1'b1;
            end else if (live_pop) begin
                out_packet      <= live_dout;
                out_is_prefetch <= 1'b0;
            end
        end
    end

    // Counts live grants that bypassed a waiting prefetch packet.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (scenario_update || pf_empty || pf_pop) begin
            starve_cnt <= '0;
        end else if (live_pop) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Sticky overflow flag and saturating drop counter.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (live_drop || pf_drop) overflow <= 1'b1;
            drop_count <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_lc_noc_injector.sv
// Self-checking bench for lc_noc_injector: vector table, directed corner sequences, random vs queue model.
module tb_lc_noc_injector;

    localparam int PW     = 40;
    localparam int DEPTH  = 4;
    localparam int STARVE = 8;

    logic          CLK = 1'b0;
    logic          reset;
    logic [PW-1:0] packet_in;
    logic [PW-1:0] prefetch_packet_in;
    logic          scenario_update;
    logic [PW-1:0] out_packet;
    logic          out_valid;
    logic          out_ready;
    logic          out_is_prefetch;
    logic          live_full;
    logic          prefetch_full;
    logic          overflow;
    logic [7:0]    drop_count;

    lc_noc_injector dut (
        .CLK                (CLK),
        .reset              (reset),
        .packet_in          (packet_in),
        .prefetch_packet_in (prefetch_packet_in),
        .scenario_update    (scenario_update),
        .out_packet         (out_packet),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_is_prefetch    (out_is_prefetch),
        .live_full          (live_full),
        .prefetch_full      (prefetch_full),
        .overflow           (overflow),
        .drop_count         (drop_count)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    // Reference model state: plain queues and counters.
    logic [PW-1:0] m_live[$];
    logic [PW-1:0] m_pf[$];
    bit            m_ov, m_opf, m_over;
    logic [PW-1:0] m_op;
    int            m_cnt, m_drops;
    logic [PW:0]   xfer_q[$];

    typedef struct {
        logic [PW-1:0] live;
        logic [PW-1:0] pf;
        logic          scen;
        logic          ready;
        logic          ev;
        logic [PW-1:0] epkt;
        logic          epf;
    } vec_t;

    function automatic logic [PW-1:0] mk(input logic [7:0] dest, input logic [31:0] data);
        return {dest, data};
    endfunction

    function automatic bit m_empty(input logic [PW-1:0] p);
        return $isunknown(p[PW-1 -: 8]) || (p[PW-1 -: 8] === 8'h00);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_live.delete(); m_pf.delete();
        m_ov = 0; m_opf = 0; m_over = 0; m_op = '0; m_cnt = 0; m_drops = 0;
    endtask

    task automatic model_drop();
        m_over = 1;
        if (m_drops < 255) m_drops++;
    endtask

    // One clock edge of the behavioural model.
    task automatic model_edge(input logic [PW-1:0] l, input logic [PW-1:0] p, input bit s, input bit r);
        bit load, lne, pne, take_pf, take_live, pf_was_empty;
        load = !m_ov || r;
        lne  = m_live.size() > 0;
        pne  = m_pf.size() > 0 && !s;
        pf_was_empty = m_pf.size() == 0;
        take_pf = 0; take_live = 0;
        if (load) begin
            if (pne && (!lne || m_cnt == STARVE)) take_pf = 1;
            else if (lne) take_live = 1;
        end
        if (s || take_pf || pf_was_empty) m_cnt = 0;
        else if (take_live) m_cnt++;
        if (load) begin
            m_ov = take_pf || take_live;
            if (take_pf)   begin m_op = m_pf.pop_front();   m_opf = 1; end
            if (take_live) begin m_op = m_live.pop_front(); m_opf = 0; end
        end
        if (s) m_pf.delete();
        if (!m_empty(l)) begin
            if (m_live.size() < DEPTH) m_live.push_back(l); else model_drop();
        end
        if (!s && !m_empty(p)) begin
            if (m_pf.size() < DEPTH) m_pf.push_back(p); else model_drop();
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            chk("out_packet", 64'(out_packet), 64'(m_op));
            chk("out_is_prefetch", 64'(out_is_prefetch), 64'(m_opf));
        end
        chk("live_full", 64'(live_full), 64'(m_live.size() == DEPTH));
        chk("prefetch_full", 64'(prefetch_full), 64'(m_pf.size() == DEPTH));
        chk("overflow", 64'(overflow), 64'(m_over));
        chk("drop_count", 64'(drop_count), 64'(m_drops));
    endtask

    // Drive one cycle of inputs, log any transfer, advance DUT and model, compare.
    task automatic step(input logic [PW-1:0] l, input logic [PW-1:0] p, input bit s, input bit r);
        packet_in = l; prefetch_packet_in = p; scenario_update = s; out_ready = r;
        if (out_valid && r) xfer_q.push_back({out_is_prefetch, out_packet});
        @(posedge CLK);
        model_edge(l, p, s, r);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0, r);
    endtask

    initial begin
        vec_t          vecs[7];
        logic [PW-1:0] zpkt;
        int            nlive;
        bit            seen;

        reset = 1'b1; packet_in = '0; prefetch_packet_in = '0;
        scenario_update = 1'b0; out_ready = 1'b0;
        model_reset();
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_packet", 64'(out_packet), 64'd0);
        chk("rst_out_is_prefetch", 64'(out_is_prefetch), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_fulls", 64'({live_full, prefetch_full}), 64'd0);
        reset = 1'b0;

        // Latency of one live packet, then live-before-prefetch on simultaneous inputs.
        vecs[0] = '{mk(8'h08, 32'h19), '0, 0, 1, 0, '0, 0};
        vecs[1] = '{'0, '0, 0, 1, 1, mk(8'h08, 32'h19), 0};
        vecs[2] = '{'0, '0, 0, 1, 0, '0, 0};
        vecs[3] = '{mk(8'h01, 32'hA), mk(8'h02, 32'hB), 0, 1, 0, '0, 0};
        vecs[4] = '{'0, '0, 0, 1, 1, mk(8'h01, 32'hA), 0};
        vecs[5] = '{'0, '0, 0, 1, 1, mk(8'h02, 32'hB), 1};
        vecs[6] = '{'0, '0, 0, 1, 0, '0, 0};
        for (int i = 0; i < 7; i++) begin
            step(vecs[i].live, vecs[i].pf, vecs[i].scen, vecs[i].ready);
            chk("vec_valid", 64'(out_valid), 64'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk("vec_packet", 64'(out_packet), 64'(vecs[i].epkt));
                chk("vec_is_prefetch", 64'(out_is_prefetch), 64'(vecs[i].epf));
            end
        end

        // Backpressure: six live packets into a four-deep FIFO behind a stalled output.
        for (int i = 1; i <= 6; i++) step(mk(8'h01, 32'(i)), '0, 1'b0, 1'b0);
        chk("bp_held_packet", 64'(out_packet), 64'(mk(8'h01, 32'd1)));
        chk("bp_live_full", 64'(live_full), 64'd1);
        chk("bp_overflow", 64'(overflow), 64'd1);
        chk("bp_drop_count", 64'(drop_count), 64'd1);
        xfer_q.delete();
        idle(7, 1'b1);
        chk("bp_xfer_count", 64'(xfer_q.size()), 64'd5);
        for (int i = 0; i < 5 && i < xfer_q.size(); i++)
            chk("bp_xfer_order", 64'(xfer_q[i]), 64'({1'b0, mk(8'h01, 32'(i + 1))}));

        // Starvation: continuous live stream with one prefetch packet waiting.
        for (int i = 0; i < 3; i++) step(mk(8'h01, 32'h100 + 32'(i)), '0, 1'b0, 1'b1);
        step(mk(8'h01, 32'h103), mk(8'h6F, 32'h30), 1'b0, 1'b1);
        nlive = 0; seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            step(mk(8'h01, 32'h110 + 32'(i)), '0, 1'b0, 1'b1);
            if (out_valid && out_is_prefetch) seen = 1;
            else if (out_valid) nlive++;
        end
        chk("starve_live_grants", 64'(nlive), 64'd8);
        chk("starve_pf_packet", 64'({out_is_prefetch, out_packet}), 64'({1'b1, mk(8'h6F, 32'h30)}));
        step(mk(8'h01, 32'h200), '0, 1'b0, 1'b1);
        chk("starve_resume", 64'({out_valid, out_is_prefetch}), 64'b10);
        idle(4, 1'b1);

        // Scenario flush with one prefetch packet already registered.
        for (int i = 1; i <= 3; i++) step('0, mk(8'h02, 32'h40 + 32'(i)), 1'b0, 1'b0);
        step('0, mk(8'h02, 32'h44), 1'b1, 1'b0);
        chk("flush_prefetch_full", 64'(prefetch_full), 64'd0);
        xfer_q.delete();
        idle(5, 1'b1);
        chk("flush_xfer_count", 64'(xfer_q.size()), 64'd1);
        if (xfer_q.size() > 0)
            chk("flush_xfer_packet", 64'(xfer_q[0]), 64'({1'b1, mk(8'h02, 32'h41)}));
        chk("flush_drop_count", 64'(drop_count), 64'd1);

        // Empty-destination filter: zero and undriven destinations.
        zpkt = {8'hzz, 32'h5};
        nlive = 0;
        for (int i = 0; i < 20; i++) begin
            step(mk(8'h00, 32'h77), zpkt, 1'b0, 1'b1);
            if (out_valid) nlive++;
        end
        chk("empty_filter_valid", 64'(nlive), 64'd0);

        // Drop counter saturation under long backpressure.
        for (int i = 0; i < 270; i++) step(mk(8'h04, 32'(i)), '0, 1'b0, 1'b0);
        chk("sat_drop_count", 64'(drop_count), 64'd255);
        chk("sat_valid_held", 64'(out_valid), 64'd1);

        // Asynchronous reset mid-cycle while a packet is held.
        #2 reset = 1'b1;
        #1;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_drop_count", 64'(drop_count), 64'd0);
        chk("async_rst_live_full", 64'(live_full), 64'd0);
        #2 reset = 1'b0;
        model_reset();
        idle(2, 1'b1);

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            logic [PW-1:0] l, p;
            l = ($urandom_range(3) == 0) ? mk(8'h00, $urandom) : mk(8'($urandom), $urandom);
            p = ($urandom_range(2) == 0) ? mk(8'($urandom), $urandom) : '0;
            step(l, p, $urandom_range(19) == 0, $urandom_range(2) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
